// File: rtl/mem_pkg.sv
// Shared memory-system definitions: word size, address map regions and the region type.
package mem_pkg;

  localparam int unsigned WORD_SIZE = 32;

  localparam logic [31:0] MEM_BASE = 32'h0000_0000;
  localparam logic [31:0] MEM_SIZE = 32'h0002_0000;
  localparam logic [31:0] IO_BASE  = 32'h8000_0000;
  localparam logic [31:0] IO_SIZE  = 32'h0001_0000;

  typedef enum logic [1:0] {
    REG_INVALID,
    REG_MEM,
    REG_IO
  } region_e;

  // Offset compare avoids an always-true "addr >= 0" when a base is zero.
  function automatic logic in_region(logic [31:0] a, logic [31:0] base, logic [31:0] size);
    return (a - base) < size;
  endfunction

endpackage

// File: rtl/memory_map_decode.sv
// Combinational byte-address to region classifier, shared by the caches and the arbiter.
module memory_map_decode
  import mem_pkg::*;
(
  input  logic [31:0] addr,
  output region_e     region
);

  always_comb begin
    region = REG_INVALID;
    if (in_region(addr, MEM_BASE, MEM_SIZE)) begin
      region = REG_MEM;
    end else if (in_region(addr, IO_BASE, IO_SIZE)) begin
      region = REG_IO;
    end
  end

endmodule

// File: rtl/write_through_cache_mm.sv
// Direct-mapped write-through/write-allocate cache, one word per line, with MMIO bypass.
// Request path is purely combinational; the requester holds its request while stalled.
module write_through_cache_mm
  import mem_pkg::*;
#(
  parameter int unsigned IDX_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 re,
  input  logic                 wr,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 cache_miss_stall,
  output logic                 valid_addr,
  output logic                 cacheable,
  output logic [31:0]          ext_addr,
  output logic [WORD_SIZE-1:0] ext_data_out,
  input  logic [WORD_SIZE-1:0] ext_data_in,
  output logic                 ext_re,
  output logic                 ext_wr,
  input  logic                 ext_ack
);

  localparam int unsigned LINES    = 1 << IDX_BITS;
  localparam int unsigned TAG_BITS = 30 - IDX_BITS;

  region_e region;

  memory_map_decode u_decode (
    .addr   (addr),
    .region (region)
  );

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [WORD_SIZE-1:0] data_q [LINES];

  logic [IDX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]  tag;
  logic                 hit;
  logic                 fill;
  logic [WORD_SIZE-1:0] fill_data;

  assign idx          = addr[IDX_BITS+1:2];
  assign tag          = addr[31:IDX_BITS+2];
  assign cacheable    = (region == REG_MEM);
  assign valid_addr   = (region != REG_INVALID);
  assign ext_addr     = {addr[31:2], 2'b00};
  assign ext_data_out = data_in;
  assign hit          = re & cacheable & valid_q[idx] & (tag_q[idx] == tag);

  always_comb begin
    data_out         = '0;
    cache_miss_stall = 1'b0;
    ext_re           = 1'b0;
    ext_wr           = 1'b0;
    fill             = 1'b0;
    fill_data        = data_in;
    if (!rst) begin
      case (region)
        REG_MEM: begin
          if (wr) begin
            ext_wr           = 1'b1;
            cache_miss_stall = ~ext_ack;
            fill             = ext_ack;
          end else if (hit) begin
            data_out = data_q[idx];
          end else if (re) begin
            ext_re           = 1'b1;
            cache_miss_stall = ~ext_ack;
            fill             = ext_ack;
            fill_data        = ext_data_in;
            if (ext_ack) data_out = ext_data_in;
          end
        end
        REG_IO: begin
          if (wr) begin
            ext_wr           = 1'b1;
            cache_miss_stall = ~ext_ack;
          end else if (re) begin
            ext_re           = 1'b1;
            cache_miss_stall = ~ext_ack;
            if (ext_ack) data_out = ext_data_in;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set, so no reset.
  always_ff @(posedge clk) begin
    if (fill && !rst) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= fill_data;
    end
  end

endmodule

// File: tb/tb_write_through_cache_mm.sv
// Directed self-checking bench for write_through_cache_mm.
module tb_write_through_cache_mm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        re;
  logic        wr;
  logic [31:0] data_out;
  logic        cache_miss_stall;
  logic        valid_addr;
  logic        cacheable;
  logic [31:0] ext_addr;
  logic [31:0] ext_data_out;
  logic [31:0] ext_data_in;
  logic        ext_re;
  logic        ext_wr;
  logic        ext_ack;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  write_through_cache_mm dut (
    .clk              (clk),
    .rst              (rst),
    .addr             (addr),
    .data_in          (data_in),
    .re               (re),
    .wr               (wr),
    .data_out         (data_out),
    .cache_miss_stall (cache_miss_stall),
    .valid_addr       (valid_addr),
    .cacheable        (cacheable),
    .ext_addr         (ext_addr),
    .ext_data_out     (ext_data_out),
    .ext_data_in      (ext_data_in),
    .ext_re           (ext_re),
    .ext_wr           (ext_wr),
    .ext_ack          (ext_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply a request just after the falling edge, then let the combinational path settle.
  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic ack, input logic [31:0] xd);
    @(negedge clk);
    re = r; wr = w; addr = a; data_in = d; ext_ack = ack; ext_data_in = xd;
    #1;
  endtask

  // Outputs of a stalled miss: strobe raised, stall high, no data yet.
  task automatic chk_miss(input string tag, input logic is_wr);
    chk({tag, " stall"}, 32'(cache_miss_stall), 32'd1);
    chk({tag, " ext_re"}, 32'(ext_re), 32'(!is_wr));
    chk({tag, " ext_wr"}, 32'(ext_wr), 32'(is_wr));
    chk({tag, " data_out"}, data_out, 32'h0);
  endtask

  task automatic chk_hit(input string tag, input logic [31:0] exp);
    chk({tag, " stall"}, 32'(cache_miss_stall), 32'd0);
    chk({tag, " ext_re"}, 32'(ext_re), 32'd0);
    chk({tag, " data_out"}, data_out, exp);
  endtask

  initial begin
    rst = 1'b1; re = 1'b1; wr = 1'b0; addr = 32'h40; data_in = '0;
    ext_ack = 1'b0; ext_data_in = '0;
    #1;
    chk("rst stall", 32'(cache_miss_stall), 32'd0);
    chk("rst ext_re", 32'(ext_re), 32'd0);
    chk("rst ext_wr", 32'(ext_wr), 32'd0);
    chk("rst data_out", data_out, 32'h0);
    chk("rst valid_addr", 32'(valid_addr), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Cold read miss, two wait cycles then ack.
    drive(1, 0, 32'h40, 0, 0, 32'hFFFF_FFFF);
    chk_miss("cold0", 0);
    chk("cold ext_addr", ext_addr, 32'h40);
    drive(1, 0, 32'h40, 0, 0, 32'hFFFF_FFFF);
    chk_miss("cold1", 0);
    drive(1, 0, 32'h40, 0, 1, 32'hDEAD_BEEF);
    chk("cold ack stall", 32'(cache_miss_stall), 32'd0);
    chk("cold ack data", data_out, 32'hDEAD_BEEF);
    // Hit; a stray ack with no strobe must be ignored.
    drive(1, 0, 32'h43, 0, 1, 32'h5555_5555);
    chk_hit("hit40", 32'hDEAD_BEEF);
    chk("hit ext_addr", ext_addr, 32'h40);

    // Write-through.
    drive(0, 1, 32'h40, 32'h1234_5678, 0, 0);
    chk_miss("wr40", 1);
    chk("wr ext_data_out", ext_data_out, 32'h1234_5678);
    drive(0, 1, 32'h40, 32'h1234_5678, 1, 0);
    chk("wr ack stall", 32'(cache_miss_stall), 32'd0);
    chk("wr ack data_out", data_out, 32'h0);
    drive(1, 0, 32'h40, 0, 0, 0);
    chk_hit("hit after wr", 32'h1234_5678);

    // re and wr together: write wins.
    drive(1, 1, 32'h40, 32'hCAFE_F00D, 0, 0);
    chk_miss("rw", 1);
    drive(1, 1, 32'h40, 32'hCAFE_F00D, 1, 0);
    drive(1, 0, 32'h40, 0, 0, 0);
    chk_hit("hit after rw", 32'hCAFE_F00D);

    // Conflict eviction: 0x140 shares index 16 with 0x40.
    drive(1, 0, 32'h140, 0, 0, 0);
    chk_miss("conf140", 0);
    drive(1, 0, 32'h140, 0, 1, 32'h1111_1111);
    chk("conf140 data", data_out, 32'h1111_1111);
    drive(1, 0, 32'h40, 0, 0, 0);
    chk_miss("evict40", 0);
    drive(1, 0, 32'h40, 0, 1, 32'h2222_2222);
    chk("evict40 data", data_out, 32'h2222_2222);
    drive(1, 0, 32'h140, 0, 0, 0);
    chk_miss("evict140", 0);
    drive(1, 0, 32'h40, 0, 0, 0);
    chk_hit("hit40 again", 32'h2222_2222);

    // MMIO bypass: every read goes out.
    drive(1, 0, 32'h8000_0004, 0, 0, 0);
    chk_miss("io0", 0);
    chk("io cacheable", 32'(cacheable), 32'd0);
    chk("io valid_addr", 32'(valid_addr), 32'd1);
    drive(1, 0, 32'h8000_0004, 0, 1, 32'hA5A5_A5A5);
    chk("io0 data", data_out, 32'hA5A5_A5A5);
    drive(1, 0, 32'h8000_0004, 0, 0, 0);
    chk_miss("io1", 0);
    drive(1, 0, 32'h8000_0004, 0, 1, 32'h5A5A_5A5A);
    chk("io1 data", data_out, 32'h5A5A_5A5A);
    drive(0, 1, 32'h8000_0008, 32'h77, 0, 0);
    chk_miss("iowr", 1);

    // Invalid address and map boundaries.
    drive(1, 0, 32'h4000_0000, 0, 1, 32'h9999_9999);
    chk("inv valid_addr", 32'(valid_addr), 32'd0);
    chk_hit("inv", 32'h0);
    chk("inv ext_wr", 32'(ext_wr), 32'd0);
    drive(0, 0, 32'h0001_FFFC, 0, 0, 0);
    chk("mem top cacheable", 32'(cacheable), 32'd1);
    drive(0, 0, 32'h0002_0000, 0, 0, 0);
    chk("mem end cacheable", 32'(cacheable), 32'd0);
    chk("mem end valid", 32'(valid_addr), 32'd0);
    drive(0, 0, 32'h8000_FFFC, 0, 0, 0);
    chk("io top valid", 32'(valid_addr), 32'd1);
    drive(0, 0, 32'h8001_0000, 0, 0, 0);
    chk("io end valid", 32'(valid_addr), 32'd0);

    // Abandoned miss leaves the line invalid.
    drive(1, 0, 32'h80, 0, 0, 0);
    drive(0, 0, 32'h80, 0, 0, 0);
    drive(1, 0, 32'h80, 0, 0, 0);
    chk_miss("abandon", 0);

    // Reset mid-miss clears valid bits.
    drive(1, 0, 32'h44, 0, 1, 32'h4444_4444);
    drive(1, 0, 32'h44, 0, 0, 0);
    chk_hit("hit44", 32'h4444_4444);
    drive(1, 0, 32'h48, 0, 0, 0);
    chk_miss("pre-rst", 0);
    rst = 1'b1;
    #1;
    chk("rst mid ext_re", 32'(ext_re), 32'd0);
    chk("rst mid stall", 32'(cache_miss_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 32'h44, 0, 0, 0);
    chk_miss("post-rst44", 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
